// File: rtl/compute_arbiter.sv
// Round-robin arbiter/sequencer sharing one compute unit among NUM_REQ requesters.
// Define ARB_WATCHDOG_EN to add a WAIT-state watchdog that forces release and sets wdog_err.
module compute_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int OP_W        = 2,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [1:0]              gnt_idx,
  output logic [NUM_REQ-1:0]      req_done,
  output logic                    cu_request,
  output logic [1:0]              cu_unit_id,
  output logic [OP_W-1:0]         cu_comp_type,
  input  logic                    cu_ready,
  output logic                    busy,
  output logic                    wdog_err
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || WDOG_CYCLES < 2) begin : g_bad_params
    $error("compute_arbiter: NUM_REQ must be 2..4 and WDOG_CYCLES at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        last_grant;
  logic              seen_busy;
  logic [1:0]        pick_idx;
  logic              pick_valid;
  logic [1:0]        cand;
  logic              grant_go;
  logic              complete;
  logic              wdog_hit;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [OP_W-1:0]   op_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i] = req_op[i*OP_W +: OP_W];
    end
  end

  // Search starts just past the last served requester, so a requester that
  // re-raises right after its done pulse goes behind everyone else pending.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign grant_go = cu_ready && pick_valid;

  // The unit's done output is sticky, so completion is ready returning high
  // after it has been seen low at least once in WAIT.
  assign complete = (state == S_WAIT) && seen_busy && cu_ready;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (grant_go) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_WAIT;
      S_WAIT:    if (complete || wdog_hit) state_next = S_RELEASE;
      S_RELEASE: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sel_onehot          = '0;
    sel_onehot[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt        = '0;
    req_done   = '0;
    cu_request = 1'b0;
    busy       = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_ISSUE: begin
        gnt        = sel_onehot;
        cu_request = 1'b1;
        busy       = 1'b1;
      end
      S_WAIT: begin
        gnt  = sel_onehot;
        busy = 1'b1;
      end
      S_RELEASE: begin
        gnt      = sel_onehot;
        req_done = sel_onehot;
        busy     = 1'b1;
      end
    endcase
  end

  assign cu_unit_id = gnt_idx;

  // Index and comp_type are captured at grant; later req_op changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_idx      <= '0;
      cu_comp_type <= '0;
      last_grant   <= 2'(NUM_REQ - 1);
      seen_busy    <= 1'b0;
    end else begin
      if (state == S_IDLE && grant_go) begin
        gnt_idx      <= pick_idx;
        cu_comp_type <= op_arr[pick_idx];
      end
      if (state == S_ISSUE) begin
        seen_busy <= 1'b0;
      end else if (state == S_WAIT && !cu_ready) begin
        seen_busy <= 1'b1;
      end
      if (state == S_RELEASE) begin
        last_grant <= gnt_idx;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Fires on the WDOG_CYCLES-th WAIT cycle that has not completed.
  assign wdog_hit = (state == S_WAIT) && !complete &&
                    (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        wdog_cnt <= '0;
      end else if (state == S_WAIT) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (wdog_hit) begin
        wdog_err <= 1'b1;
      end
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_done));
  a_done_in_gnt: assert property (@(posedge clk) disable iff (rst) (req_done & ~gnt) == '0);
  a_issue_single: assert property (@(posedge clk) disable iff (rst) cu_request |=> !cu_request);
`endif

endmodule

// File: tb/tb_compute_arbiter.sv
// Randomized self-checking bench for compute_arbiter with a behavioural
// compute-unit model and a round-robin reference model.
module tb_compute_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int OP_W        = 2;
  localparam int WDOG_CYCLES = 64;

  logic                    clk;
  logic                    rst;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*OP_W-1:0] req_op;
  logic [NUM_REQ-1:0]      gnt;
  logic [1:0]              gnt_idx;
  logic [NUM_REQ-1:0]      req_done;
  logic                    cu_request;
  logic [1:0]              cu_unit_id;
  logic [OP_W-1:0]         cu_comp_type;
  logic                    cu_ready;
  logic                    busy;
  logic                    wdog_err;

  int vectors    = 0;
  int miscompares = 0;

  // Reference state: who was served last, and the op each requester raised with.
  int         last_model = NUM_REQ - 1;
  logic [1:0] ops_model [NUM_REQ];

  // Compute-unit model: ready drops when a request is seen and stays low for cu_lat cycles.
  int cu_lat  = 4;
  int cu_cnt  = 0;
  bit cu_hold = 1'b0;

  compute_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .OP_W       (OP_W),
    .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_op      (req_op),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .req_done    (req_done),
    .cu_request  (cu_request),
    .cu_unit_id  (cu_unit_id),
    .cu_comp_type(cu_comp_type),
    .cu_ready    (cu_ready),
    .busy        (busy),
    .wdog_err    (wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cu_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) cu_cnt = 0;
      else if (cu_request) cu_cnt = cu_lat;
      if (cu_cnt > 0) begin
        cu_ready = 1'b0;
        cu_cnt--;
      end else begin
        cu_ready = !cu_hold;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 3 ms");
    $fatal(1);
  end

  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] r);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [1:0] op);
    req_op[i*OP_W +: OP_W] = op;
    ops_model[i] = op;
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    req    = '0;
    req_op = '0;
    for (int i = 0; i < NUM_REQ; i++) ops_model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    last_model = NUM_REQ - 1;
  endtask

  // One full operation: grant one cycle after the IDLE edge, lat busy cycles,
  // done pulse the cycle after ready returns, then back to IDLE.
  task automatic do_op(input int exp_idx, input logic [1:0] exp_op, input int lat, input bit mutate);
    int waited;
    logic [NUM_REQ-1:0] oh;
    oh     = 4'b0001 << exp_idx;
    cu_lat = lat;
    waited = 0;
    do begin
      tick();
      waited++;
      vectors++;
      if (req_done !== '0) begin
        miscompares++;
        $display("FAIL stray_done: req_done=%b while waiting for grant, required 0000", req_done);
      end
    end while (gnt === '0 && waited < 100);
    vectors++;
    if (gnt === '0) begin
      miscompares++;
      $display("FAIL grant_timeout: no grant after %0d cycles, required grant of %0d", waited, exp_idx);
      return;
    end
    vectors++;
    if (waited != 1) begin
      miscompares++;
      $display("FAIL grant_latency: grant after %0d cycles, required 1", waited);
    end
    vectors++;
    if ({gnt, gnt_idx, cu_request, cu_unit_id, cu_comp_type, busy, wdog_err} !==
        {oh, 2'(exp_idx), 1'b1, 2'(exp_idx), exp_op, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL grant: gnt=%b idx=%0d req=%b uid=%0d op=%0d busy=%b, required gnt=%b idx=%0d req=1 uid=%0d op=%0d busy=1",
               gnt, gnt_idx, cu_request, cu_unit_id, cu_comp_type, busy, oh, exp_idx, exp_idx, exp_op);
    end
    if (mutate) begin
      req[exp_idx] = 1'b0;
      req_op[exp_idx*OP_W +: OP_W] = ~exp_op;
    end
    for (int c = 1; c <= lat; c++) begin
      tick();
      vectors++;
      if ({gnt, req_done, cu_request, busy} !== {oh, 4'b0000, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL wait_phase[%0d]: gnt=%b done=%b cu_req=%b busy=%b, required gnt=%b done=0000 cu_req=0 busy=1",
                 c, gnt, req_done, cu_request, busy, oh);
      end
    end
    tick();
    vectors++;
    if ({gnt, req_done, cu_comp_type} !== {oh, oh, exp_op}) begin
      miscompares++;
      $display("FAIL done_pulse: gnt=%b done=%b op=%0d, required gnt=%b done=%b op=%0d",
               gnt, req_done, cu_comp_type, oh, oh, exp_op);
    end
    req[exp_idx] = 1'b0;
    tick();
    vectors++;
    if ({gnt, req_done, cu_request, busy} !== '0) begin
      miscompares++;
      $display("FAIL release_idle: gnt=%b done=%b cu_req=%b busy=%b, required all 0",
               gnt, req_done, cu_request, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req_op = '0;
    #12;
    vectors++;
    if ({gnt, gnt_idx, req_done, cu_request, cu_unit_id, cu_comp_type, busy, wdog_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: gnt=%b idx=%0d done=%b cu_req=%b uid=%0d op=%0d busy=%b wdog=%b, required all 0",
               gnt, gnt_idx, req_done, cu_request, cu_unit_id, cu_comp_type, busy, wdog_err);
    end
    apply_reset();
    tick();
    vectors++;
    if ({gnt, busy, cu_request} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: gnt=%b busy=%b cu_req=%b with no requests, required all 0", gnt, busy, cu_request);
    end
  endtask

  task automatic test_single();
    int e;
    apply_reset();
    req = 4'b0001;
    set_op(0, 2'd1);
    e = rr_pick(last_model, req);
    do_op(e, ops_model[e], 20, 1'b0);
    last_model = e;
  endtask

  task automatic test_ready_low();
    int e;
    cu_hold = 1'b1;
    req     = 4'b0010;
    set_op(1, 2'd2);
    repeat (6) begin
      tick();
      vectors++;
      if ({gnt, cu_request, busy} !== '0) begin
        miscompares++;
        $display("FAIL ready_low_hold: gnt=%b cu_req=%b busy=%b with cu_ready low, required all 0", gnt, cu_request, busy);
      end
    end
    cu_hold = 1'b0;
    e = rr_pick(last_model, req);
    do_op(e, ops_model[e], 4, 1'b0);
    last_model = e;
  endtask

  task automatic test_latch_drop();
    int e;
    req = 4'b0100;
    set_op(2, 2'd0);
    e = rr_pick(last_model, req);
    do_op(e, ops_model[e], 6, 1'b1);
    last_model = e;
  endtask

  task automatic test_all_pending();
    int e;
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 2'($urandom_range(0, 3)));
    for (int n = 0; n < 8; n++) begin
      e = rr_pick(last_model, req);
      do_op(e, ops_model[e], int'($urandom_range(2, 5)), 1'b0);
      last_model = e;
      req[e] = 1'b1;
    end
  endtask

  task automatic test_reset_mid_op();
    int e;
    int waited;
    apply_reset();
    req = 4'b0100;
    set_op(2, 2'd1);
    cu_lat = 30;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (gnt === '0 && waited < 10);
    repeat (4) tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_op_busy: busy=%b before reset, required 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({gnt, gnt_idx, req_done, cu_request, cu_unit_id, cu_comp_type, busy, wdog_err} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: gnt=%b idx=%0d done=%b cu_req=%b uid=%0d op=%0d busy=%b wdog=%b, required all 0",
               gnt, gnt_idx, req_done, cu_request, cu_unit_id, cu_comp_type, busy, wdog_err);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    last_model = NUM_REQ - 1;
    req        = 4'b1001;
    set_op(0, 2'd2);
    set_op(3, 2'd3);
    repeat (2) begin
      e = rr_pick(last_model, req);
      do_op(e, ops_model[e], int'($urandom_range(2, 6)), 1'b0);
      last_model = e;
    end
  endtask

  task automatic test_random();
    int e;
    logic [NUM_REQ-1:0] raise;
    apply_reset();
    req = 4'b0110;
    set_op(1, 2'($urandom_range(0, 3)));
    set_op(2, 2'($urandom_range(0, 3)));
    for (int n = 0; n < 40; n++) begin
      e = rr_pick(last_model, req);
      do_op(e, ops_model[e], int'($urandom_range(2, 8)), ($urandom_range(0, 3) == 0));
      last_model = e;
      raise = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (raise[i] && !req[i]) begin
          req[i] = 1'b1;
          set_op(i, 2'($urandom_range(0, 3)));
        end
      end
      if (req == '0) begin
        repeat (2) begin
          tick();
          vectors++;
          if ({gnt, busy} !== '0) begin
            miscompares++;
            $display("FAIL idle_no_req: gnt=%b busy=%b with no requests, required 0", gnt, busy);
          end
        end
        e = int'($urandom_range(0, NUM_REQ - 1));
        req[e] = 1'b1;
        set_op(e, 2'($urandom_range(0, 3)));
      end
    end
    req = '0;
  endtask

`ifdef ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int e;
    apply_reset();
    req = 4'b0001;
    set_op(0, 2'd3);
    cu_lat = 100000;
    tick();
    vectors++;
    if ({gnt, cu_request} !== {4'b0001, 1'b1}) begin
      miscompares++;
      $display("FAIL wdog_grant: gnt=%b cu_req=%b, required gnt=0001 cu_req=1", gnt, cu_request);
    end
    for (int c = 1; c <= WDOG_CYCLES; c++) begin
      tick();
      vectors++;
      if ({req_done, wdog_err} !== 5'b0) begin
        miscompares++;
        $display("FAIL wdog_early[%0d]: done=%b wdog=%b, required 0000/0", c, req_done, wdog_err);
      end
    end
    tick();
    vectors++;
    if ({req_done, wdog_err} !== {4'b0001, 1'b1}) begin
      miscompares++;
      $display("FAIL wdog_fire: done=%b wdog=%b, required 0001/1", req_done, wdog_err);
    end
    cu_cnt = 0;
    req    = '0;
    tick();
    vectors++;
    if ({gnt, busy, wdog_err} !== {4'b0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL wdog_sticky: gnt=%b busy=%b wdog=%b, required 0000/0/1", gnt, busy, wdog_err);
    end
    last_model = 0;
    req = 4'b0010;
    set_op(1, 2'd1);
    e = rr_pick(last_model, req);
    cu_lat = 3;
    begin
      int waited;
      waited = 0;
      do begin
        tick();
        waited++;
      end while (gnt === '0 && waited < 20);
      vectors++;
      if ({gnt, cu_comp_type, wdog_err} !== {4'b0010, 2'd1, 1'b1}) begin
        miscompares++;
        $display("FAIL wdog_regrant: gnt=%b op=%0d wdog=%b, required 0010/1/1", gnt, cu_comp_type, wdog_err);
      end
    end
    repeat (8) tick();
    req = '0;
  endtask
`endif

  initial begin
    rst    = 1'b1;
    req    = '0;
    req_op = '0;
    test_reset();
    test_single();
    test_ready_low();
    test_latch_drop();
    test_all_pending();
    test_reset_mid_op();
    test_random();
`ifdef ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/compute_arbiter.md
Name: compute_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single shared compute unit between up to NUM_REQ requesting units (layer engines, activation stage, etc.).
- Accepts one operation request per requester, grants exactly one at a time and issues a single-cycle request to the compute unit.
- Drives unit_id/comp_type and a grant index used by the external operand mux.
- Detects completion and returns a one-cycle done pulse to the granted requester.

Parameters:
NUM_REQ, 4, number of requesters (2..4; unit_id is 2 bits)
OP_W, 2, width of comp_type encoding (ADD/MUL/TANH/RELU)
WDOG_CYCLES, 64, watchdog limit in WAIT state (used only with ARB_WATCHDOG_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester operation request, level, held until its done pulse
req_op  in  NUM_REQ*OP_W  per-requester comp_type, slice i = requester i
gnt  out  NUM_REQ  one-hot grant, high from grant through release
gnt_idx  out  2  index of granted requester (operand mux select)
req_done  out  NUM_REQ  one-hot one-cycle completion pulse
cu_request  out  1  request to compute unit
cu_unit_id  out  2  unit_id to compute unit (= gnt_idx)
cu_comp_type  out  OP_W  latched comp_type of granted requester
cu_ready  in  1  compute unit ready
busy  out  1  high whenever state != IDLE
wdog_err  out  1  sticky watchdog error (0 when macro absent)

Behaviour:
- Reset (async, any state incl. mid-op): state=IDLE; gnt=0, gnt_idx=0, req_done=0, cu_request=0, cu_unit_id=0, cu_comp_type=0, busy=0, wdog_err=0; last_grant=NUM_REQ-1, so requester 0 has first priority. An in-flight compute is abandoned; its completion is never reported.
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - If cu_ready=1 and req!=0, pick the first set req[i] searching from last_grant+1 upward with wrap-around.
  - Latch gnt_idx=i, cu_comp_type=req_op[i]. Set gnt[i]=1 and go to ISSUE.
  - If cu_ready=0, no grant is made.
- ISSUE:
  - cu_request=1 for exactly this one cycle; cu_unit_id=gnt_idx.
  - Clear seen_busy; go to WAIT.
- WAIT:
  - cu_request=0. Set seen_busy when cu_ready=0 is sampled.
  - Completion: cu_ready=1 sampled while seen_busy=1. Go to RELEASE.
  - The compute unit's done output is sticky, so it is not used for completion detection.
- RELEASE:
  - req_done[gnt_idx]=1 for one cycle; gnt cleared; last_grant=gnt_idx.
  - Go to IDLE. A new grant is possible the next cycle.
- Latency: req sampled in IDLE at edge T gives gnt/cu_request at T+1. Done pulse arrives 1 cycle after completion detect. Minimum grant-to-grant spacing is 4 cycles plus compute time.
- Operands and comp_type are latched at grant. Changes to req_op afterwards are ignored.
- A requester dropping req after grant does not abort: the operation completes and req_done is still pulsed.
- A requester that re-raises req immediately after its done pulse yields to other pending requesters (round-robin fairness). If it is the only requester, it is re-granted.
- Simultaneous requests: exactly one grant per arbitration; the others wait. No requester starves; worst-case wait is NUM_REQ-1 operations.
- Requests on indices >= NUM_REQ do not exist; gnt and req_done are always one-hot or zero.

Optional Feature:
ARB_WATCHDOG_EN
- Defined:
  - A counter runs in WAIT; when it reaches WDOG_CYCLES without completion, set wdog_err=1 (sticky until rst).
  - Force RELEASE: req_done is pulsed so the requester is unblocked, and normal arbitration continues.
- Not defined: no counter; wdog_err tied 0; WAIT lasts indefinitely.

Test Plan:
- Reset, req=4'b0001, op0=MUL, unit busy 20 cycles -> gnt=0001 and cu_request 1 cycle at T+1, cu_comp_type=1, req_done[0] pulse 1 cycle after cu_ready returns high.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0,...; each done pulse is one-hot and occurs once per grant.
- cu_ready=0 in IDLE with req=0010 -> no gnt, no cu_request until cu_ready=1, then gnt=0010.
- After grant of req 2 (op ADD), change req_op[2] to RELU and drop req[2] -> cu_comp_type stays ADD; req_done[2] still pulses.
- Assert rst while in WAIT -> all outputs 0 immediately; after release with req=1001, requester 0 is granted first.
- With ARB_WATCHDOG_EN, WDOG_CYCLES=64, cu_ready held 0 after issue -> wdog_err=1 after 64 WAIT cycles, req_done pulsed, the next request is granted normally.
